// File: rtl/int_ctrl.sv
// int_ctrl: parametrised interrupt controller for the pipelined CPU.
// Each source is synchronised, edge-detected and latched as pending.
// Eligible pending sources are arbitrated and offered to the core through
// a request / acknowledge / return handshake. An unacknowledged request
// is withdrawn after TIMEOUT+1 cycles.
// Optional build macro INT_CTRL_RR_EN: when it is defined, arbitration is
// round-robin starting after the last serviced id. When it is undefined,
// arbitration is fixed priority and the lowest index wins.
module int_ctrl #(
    parameter int              NUM_SRC     = 4,
    parameter int              SYNC_STAGES = 2,
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] ARM_PC      = 32'h00000EA8,
    parameter int              TO_W        = 21,
    parameter logic [TO_W-1:0] TIMEOUT     = 21'h0EFFF,
    localparam int             ID_W        = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic [NUM_SRC-1:0] mask_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic               irq_ack_i,
    input  logic               ret_i,
    output logic               irq_o,
    output logic [ID_W-1:0]    irq_id_o,
    output logic               busy_o,
    output logic [NUM_SRC-1:0] pending_o,
    output logic               timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        SERV = 2'b10
    } state_t;

    localparam logic [NUM_SRC-1:0] SRC_ZERO = {NUM_SRC{1'b0}};
    localparam logic [NUM_SRC-1:0] SRC_ONE  = {{(NUM_SRC-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0]    ID_ZERO  = {ID_W{1'b0}};
    localparam logic [TO_W-1:0]    CNT_ZERO = {TO_W{1'b0}};
    localparam logic [TO_W-1:0]    CNT_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

    logic [NUM_SRC-1:0] sync_r [SYNC_STAGES];
    logic [NUM_SRC-1:0] prev_r;
    logic [NUM_SRC-1:0] rise_s;
    logic [NUM_SRC-1:0] pending_r;
    logic [NUM_SRC-1:0] clr_s;
    logic [NUM_SRC-1:0] elig_s;
    logic               armed_s;
    logic [ID_W-1:0]    winner_s;
    logic               withdraw_s;

    state_t             state_r;
    logic               irq_r;
    logic [ID_W-1:0]    irq_id_r;
    logic               busy_r;
    logic               timeout_r;
    logic [TO_W-1:0]    cnt_r;

    // Fixed priority: the lowest set index wins.
    function automatic logic [ID_W-1:0] fp_pick(input logic [NUM_SRC-1:0] e);
        logic [ID_W-1:0] w;
        w = ID_ZERO;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (e[i]) begin
                w = ID_W'(i);
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

`ifdef INT_CTRL_RR_EN
    logic [ID_W-1:0] last_r;

    // Round robin: search from last+1 upward and wrap around to last.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_SRC-1:0] e,
                                                input logic [ID_W-1:0]    last);
        logic [ID_W-1:0] w;
        logic            found;
        int              idx;
        w     = ID_ZERO;
        found = 1'b0;
        for (int j = 1; j <= NUM_SRC; j++) begin
            idx = (int'(last) + j) % NUM_SRC;
            if (!found && e[idx]) begin
                w     = ID_W'(idx);
                found = 1'b1;
            end else begin
                w     = w;
                found = found;
            end
        end
        return w;
    endfunction

    // Remember the id taken by the core so the next search starts after it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_r <= ID_W'(NUM_SRC - 1);
        end else if (state_r == REQ && irq_ack_i) begin
            last_r <= irq_id_r;
        end else begin
            last_r <= last_r;
        end
    end

    assign winner_s = rr_pick(elig_s, last_r);
`else
    assign winner_s = fp_pick(elig_s);
`endif

    assign rise_s  = sync_r[SYNC_STAGES-1] & ~prev_r;
    assign elig_s  = pending_r & mask_i;
    assign armed_s = (pc_i >= ARM_PC);

    // Synchronise the asynchronous sources and keep one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= SRC_ZERO;
            end
            prev_r <= SRC_ZERO;
        end else begin
            sync_r[0] <= src_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // A request leaves REQ on acknowledge or on timeout, and either exit retires its pending bit.
    always_comb begin
        withdraw_s = 1'b0;
        clr_s      = SRC_ZERO;
        if (state_r == REQ && (irq_ack_i || cnt_r == TIMEOUT)) begin
            withdraw_s = 1'b1;
            clr_s      = SRC_ONE << irq_id_r;
        end else begin
            withdraw_s = 1'b0;
            clr_s      = SRC_ZERO;
        end
    end

    // Pending latches: a new edge takes precedence over a clear in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_r <= SRC_ZERO;
        end else begin
            pending_r <= (pending_r & ~clr_s) | rise_s;
        end
    end

    // Handshake FSM with registered request, id, busy and timeout outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= IDLE;
            irq_r     <= 1'b0;
            irq_id_r  <= ID_ZERO;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
            cnt_r     <= CNT_ZERO;
        end else begin
            timeout_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    busy_r <= 1'b0;
                    if ((|elig_s) && armed_s) begin
                        state_r  <= REQ;
                        irq_r    <= 1'b1;
                        irq_id_r <= winner_s;
                        cnt_r    <= CNT_ZERO;
                    end else begin
                        irq_r    <= 1'b0;
                    end
                end
                REQ: begin
                    if (irq_ack_i) begin
                        state_r <= SERV;
                        irq_r   <= 1'b0;
                        busy_r  <= 1'b1;
                    end else if (withdraw_s) begin
                        state_r   <= IDLE;
                        irq_r     <= 1'b0;
                        timeout_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                SERV: begin
                    if (ret_i) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    irq_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign irq_o     = irq_r;
    assign irq_id_o  = irq_id_r;
    assign busy_o    = busy_r;
    assign pending_o = pending_r;
    assign timeout_o = timeout_r;

endmodule
